mem_arbiter: RTL and testbench

Shares one single-port unified memory between the instruction-fetch stage and the memory (load/store) stage of the 5-stage pipeline. It grants one requester per transaction, with data priority and an instruction-starvation guard. It holds one outstanding transaction at a time and routes the response back to the owner. A response timeout raises a sticky error flag.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and data access.
// Ports:
//   clk, rst                      clock (rising edge) and asynchronous active-high reset
//   if_req_*  / if_rsp_*          fetch request (valid/addr/ready) and response (valid/data)
//   dm_req_*  / dm_rsp_*          data request (valid/we/addr/wdata/ready) and response (valid/rdata)
//   mem_req_* / mem_rsp_*         memory request (valid/we/addr/wdata/ready) and response (valid/rdata)
//   busy                          a transaction is in flight
//   err                           sticky response-timeout flag
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        dm_req_valid,
    input  logic        dm_req_we,
    input  logic [31:0] dm_req_addr,
    input  logic [31:0] dm_req_wdata,
    output logic        dm_req_ready,
    output logic        dm_rsp_valid,
    output logic [31:0] dm_rsp_rdata,
    output logic        mem_req_valid,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        busy,
    output logic        err
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state, state_nx;
    logic          owner;
    logic          we_q;
    logic [31:0]   addr_q, wdata_q, rdata;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] wait_cnt;
    logic          grant_dm, grant_if, timeout, done;

    // Data wins ties unless fetch has already lost STARVE_MAX times in a row.
    assign grant_dm = dm_req_valid && (!if_req_valid || starve_cnt != SW'(STARVE_MAX));
    assign grant_if = if_req_valid && !grant_dm;
    assign timeout  = wait_cnt == TW'(TIMEOUT);
    assign done     = state == WAIT && (mem_rsp_valid || timeout);
    // Stores always return 0, and an aborted transaction returns 0.
    assign rdata    = (mem_rsp_valid && !we_q) ? mem_rsp_rdata : '0;

    assign mem_req_valid = state == REQ;
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign busy          = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        if_req_ready = 1'b0;
        dm_req_ready = 1'b0;
        case (state)
            IDLE: begin
                // Gated by rst so the ready outputs read 0 while reset is held.
                if_req_ready = grant_if && !rst;
                dm_req_ready = grant_dm && !rst;
                if (grant_if || grant_dm) state_nx = REQ;
            end
            REQ:     if (mem_req_ready) state_nx = WAIT;
            WAIT:    if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            starve_cnt   <= '0;
            wait_cnt     <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            dm_rsp_valid <= 1'b0;
            dm_rsp_rdata <= '0;
            err          <= 1'b0;
        end else begin
            if (state == IDLE) begin
                starve_cnt <= (grant_if || !if_req_valid) ? '0 :
                              (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
                if (grant_if || grant_dm) begin
                    owner   <= grant_dm;
                    we_q    <= grant_dm && dm_req_we;
                    addr_q  <= grant_dm ? dm_req_addr : if_req_addr;
                    wdata_q <= grant_dm ? dm_req_wdata : '0;
                end
            end
            wait_cnt     <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if_rsp_valid <= done && !owner;
            dm_rsp_valid <= done && owner;
            if_rsp_data  <= (done && !owner) ? rdata : '0;
            dm_rsp_rdata <= (done && owner) ? rdata : '0;
            err          <= err | (state == WAIT && !mem_rsp_valid && timeout);
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (STARVE_MAX=4, TIMEOUT=8).
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = '0;
    logic        if_req_ready, if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        dm_req_valid = 1'b0, dm_req_we = 1'b0;
    logic [31:0] dm_req_addr = '0, dm_req_wdata = '0;
    logic        dm_req_ready, dm_rsp_valid;
    logic [31:0] dm_rsp_rdata;
    logic        mem_req_valid, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        busy, err;
    int          n_cmp = 0, n_err = 0;

    mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
        .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts at a negedge in IDLE; ends at the negedge of the response pulse.
    task automatic txn(input string tag, input logic dm, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] mdata, input logic [31:0] exp);
        if (dm) begin
            dm_req_valid = 1'b1; dm_req_we = we; dm_req_addr = addr; dm_req_wdata = wdata;
        end else begin
            if_req_valid = 1'b1; if_req_addr = addr;
        end
        #1;
        chk({tag, " ready"}, dm ? dm_req_ready : if_req_ready, 1);
        @(negedge clk);
        dm_req_valid = 1'b0; if_req_valid = 1'b0;
        chk({tag, " mem_valid"}, mem_req_valid, 1);
        chk({tag, " mem_addr"}, mem_req_addr, addr);
        chk({tag, " mem_we"}, mem_req_we, dm && we);
        chk({tag, " mem_wdata"}, mem_req_wdata, dm ? wdata : 0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = mdata;
        chk({tag, " busy"}, busy, 1);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk({tag, " if_rsp_valid"}, if_rsp_valid, !dm);
        chk({tag, " dm_rsp_valid"}, dm_rsp_valid, dm);
        chk({tag, " rsp_data"}, dm ? dm_rsp_rdata : if_rsp_data, exp);
    endtask

    initial begin
        int cnt;
        logic [9:0] order = 10'b1111011110;
        if_req_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst if_ready", if_req_ready, 0);
        chk("rst busy", busy, 0);
        chk("rst err", err, 0);
        chk("rst mem_valid", mem_req_valid, 0);
        if_req_valid = 1'b0; rst = 1'b0;
        @(negedge clk);

        txn("fetch", 0, 0, 32'h10, 0, 32'h0051_3093, 32'h0051_3093);
        txn("store", 1, 1, 32'h100, 32'hCAFE_F00D, 32'h1234_5678, 0);
        txn("load", 1, 0, 32'h200, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Contention: order bit i = 1 means dm expected to win grant i.
        if_req_valid = 1'b1; if_req_addr = 32'h20;
        dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'h400;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("grant%0d dm", i), dm_req_ready, order[9-i]);
            chk($sformatf("grant%0d if", i), if_req_ready, !order[9-i]);
            @(negedge clk);
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = i;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
        end
        if_req_valid = 1'b0; dm_req_valid = 1'b0;

        // Back-pressure: memory not ready for 5 cycles.
        dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_addr = 32'h300; dm_req_wdata = 32'h55AA_33CC;
        #1;
        chk("bp dm_ready", dm_req_ready, 1);
        @(negedge clk);
        dm_req_valid = 1'b0; if_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp mem_valid", mem_req_valid, 1);
            chk("bp addr", mem_req_addr, 32'h300);
            chk("bp wdata", mem_req_wdata, 32'h55AA_33CC);
            chk("bp busy", busy, 1);
            chk("bp readies", {if_req_ready, dm_req_ready}, 0);
            @(negedge clk);
        end
        if_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h9999_9999;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("bp dm_rsp_valid", dm_rsp_valid, 1);
        chk("bp dm_rsp_rdata", dm_rsp_rdata, 0);

        // Timeout: no response, expect abort 9 cycles after entering WAIT.
        chk("pre-to err", err, 0);
        if_req_valid = 1'b1; if_req_addr = 32'h40;
        @(negedge clk);
        if_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        cnt = 0;
        while (!if_rsp_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("to latency", cnt, 9);
        chk("to data", if_rsp_data, 0);
        chk("to err", err, 1);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1111_1111;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("late if_rsp", if_rsp_valid, 0);
        chk("late busy", busy, 0);
        txn("post-to", 0, 0, 32'h44, 0, 32'h2222_2222, 32'h2222_2222);
        chk("err sticky", err, 1);

        // Async reset in the middle of WAIT.
        dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'h80;
        @(negedge clk);
        dm_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst busy", busy, 0);
        chk("arst err", err, 0);
        chk("arst mem_valid", mem_req_valid, 0);
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h7777_7777;
        @(negedge clk);
        rst = 1'b0;
        chk("arst dm_rsp a", dm_rsp_valid, 0);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("arst dm_rsp b", dm_rsp_valid, 0);
        chk("arst busy b", busy, 0);
        txn("after-rst", 0, 0, 32'h10, 0, 32'h0051_3093, 32'h0051_3093);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
